// File: rtl/punc_loader_pkg.sv
// Shared definitions for the PUnC boot loader: state encodings and the default frame marker.
// PUNC_LOADER_CSUM_EN adds the checksum trailer states.
package punc_loader_pkg;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'h5A;

   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_ADDR_HI = 4'd1,
      ST_ADDR_LO = 4'd2,
      ST_CNT_HI  = 4'd3,
      ST_CNT_LO  = 4'd4,
      ST_DATA_HI = 4'd5,
      ST_DATA_LO = 4'd6,
      ST_WRITE   = 4'd7,
`ifdef PUNC_LOADER_CSUM_EN
      ST_CSUM_HI = 4'd8,
      ST_CSUM_LO = 4'd9,
`endif
      ST_DONE    = 4'd10,
      ST_ERR     = 4'd11
   } loader_state_e;

endpackage

// File: rtl/punc_loader_if.sv
// Byte-stream input and memory write port of the PUnC loader.
// master = host/memory side, slave = loader side.
interface punc_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        mem_wr_en;
   logic [15:0] mem_wr_addr;
   logic [15:0] mem_wr_data;

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
   );

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, mem_wr_en, mem_wr_addr, mem_wr_data
   );
endinterface

// File: rtl/punc_loader_asm.sv
// Big-endian byte-pair assembler: captures the high byte, then presents the full word
// together with the low byte, pulsing word_valid for that one cycle.
module punc_loader_asm (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  byte_data,
   input  logic        byte_en,
   output logic [15:0] word,
   output logic        word_valid
);

   logic [7:0] hi_reg;
   logic       phase_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hi_reg    <= 8'h00;
         phase_reg <= 1'b0;
      end else if (byte_en) begin
         if (!phase_reg) begin
            hi_reg <= byte_data;
         end
         phase_reg <= ~phase_reg;
      end
   end

   assign word       = {hi_reg, byte_data};
   assign word_valid = byte_en & phase_reg;

endmodule

// File: rtl/punc_loader.sv
// PUnC boot loader: parses SYNC/addr/count/data frames from a byte stream into memory writes,
// holding the core in reset until the image is in. PUNC_LOADER_CSUM_EN enables the checksum trailer.
module punc_loader
   import punc_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   punc_loader_if.slave    bus,
   output logic            cpu_hold,
   output logic            load_done,
   output logic            load_err
);

`ifdef PUNC_LOADER_CSUM_EN
   localparam loader_state_e END_STATE = ST_CSUM_HI;
`else
   localparam loader_state_e END_STATE = ST_DONE;
`endif

   loader_state_e state_reg, state_next;
   logic [15:0]   addr_reg;
   logic [15:0]   cnt_reg;
   logic [15:0]   data_reg;
`ifdef PUNC_LOADER_CSUM_EN
   logic [15:0]   sum_reg;
`endif

   logic          accept;
   logic          asm_en;
   logic [15:0]   word;
   logic          word_valid;

   // rx_ready is gated by rst so nothing is accepted while reset is held
   assign bus.rx_ready = rst & ~(state_reg inside {ST_WRITE, ST_DONE, ST_ERR});
   assign accept       = bus.rx_valid & bus.rx_ready;
   // The sync byte never enters the assembler, keeping hi/lo pairing aligned with the fields
   assign asm_en       = accept & (state_reg != ST_IDLE);

   punc_loader_asm u_asm (
      .clk        (clk),
      .rst        (rst),
      .byte_data  (bus.rx_data),
      .byte_en    (asm_en),
      .word       (word),
      .word_valid (word_valid)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (accept && bus.rx_data == SYNC_BYTE) state_next = ST_ADDR_HI;
         ST_ADDR_HI: if (accept) state_next = ST_ADDR_LO;
         ST_ADDR_LO: if (word_valid) state_next = ST_CNT_HI;
         ST_CNT_HI:  if (accept) state_next = ST_CNT_LO;
         ST_CNT_LO:  if (word_valid) state_next = (word == 16'h0000) ? END_STATE : ST_DATA_HI;
         ST_DATA_HI: if (accept) state_next = ST_DATA_LO;
         ST_DATA_LO: if (word_valid) state_next = ST_WRITE;
         ST_WRITE:   state_next = (cnt_reg == 16'h0001) ? END_STATE : ST_DATA_HI;
`ifdef PUNC_LOADER_CSUM_EN
         ST_CSUM_HI: if (accept) state_next = ST_CSUM_LO;
         ST_CSUM_LO: if (word_valid) state_next = (word == sum_reg) ? ST_DONE : ST_ERR;
`endif
         ST_DONE:    state_next = ST_DONE;
         ST_ERR:     state_next = ST_ERR;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr_reg <= 16'h0000;
         cnt_reg  <= 16'h0000;
         data_reg <= 16'h0000;
`ifdef PUNC_LOADER_CSUM_EN
         sum_reg  <= 16'h0000;
`endif
      end else begin
         case (state_reg)
            ST_ADDR_LO: if (word_valid) addr_reg <= word;
            ST_CNT_LO:  if (word_valid) cnt_reg <= word;
            ST_DATA_LO: begin
               if (word_valid) begin
                  data_reg <= word;
`ifdef PUNC_LOADER_CSUM_EN
                  sum_reg  <= sum_reg + word;
`endif
               end
            end
            ST_WRITE: begin
               // address wraps naturally at 16 bits
               addr_reg <= addr_reg + 16'h0001;
               cnt_reg  <= cnt_reg - 16'h0001;
            end
            default: ;
         endcase
      end
   end

   assign bus.mem_wr_en   = (state_reg == ST_WRITE);
   assign bus.mem_wr_addr = addr_reg;
   assign bus.mem_wr_data = data_reg;

   assign cpu_hold  = (state_reg != ST_DONE);
   assign load_done = (state_reg == ST_DONE);
`ifdef PUNC_LOADER_CSUM_EN
   assign load_err  = (state_reg == ST_ERR);
`else
   assign load_err  = 1'b0;
`endif

endmodule
